// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//
// Purpose:
//   Fetch/decode stage that feeds the halt clock-gate stage. It walks a program
//   ROM with a program counter and latches each instruction word. It presents
//   the 2-bit opcode on `instruct` and the operand on `operand`. It also
//   sequences INC, JNO, HALT and NOP instructions.
//
//   Every instruction takes exactly four cycles: FETCH -> WAIT -> LOAD -> EXEC.
//   A HALT parks the FSM in HALTED until `resume` is seen high.
//
// Instruction word (DW bits, DW >= AW+2):
//   [DW-1:DW-2] opcode : 00 INC, 01 JNO, 10 HALT, 11 NOP
//   [AW-1:0]    operand: register index (INC) or jump target (JNO)
//
// Parameters:
//   AW       - program counter / ROM address / operand width
//   DW       - instruction word width
//   RESET_PC - program counter value loaded on reset
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous, active-high reset
//   step       in   (SINGLE_STEP_EN only) lets FETCH advance by one instruction
//   imem_data  in   ROM read data, valid one cycle after imem_addr
//   ovf        in   accumulator overflow, sampled only in EXEC of a JNO
//   resume     in   level; leaves HALTED when high
//   imem_addr  out  registered ROM read address
//   instruct   out  current opcode to the halt stage
//   operand    out  operand field of the current instruction
//   inc_en     out  one-cycle strobe: increment register `operand`
//   halted     out  high while in HALTED
//   pc         out  current program counter
//
// Configuration macro:
//   SINGLE_STEP_EN - when defined, adds the `step` input. FETCH then waits for
//                    step==1 before advancing. HALTED still needs resume.
// -----------------------------------------------------------------------------
module fetch_sequencer #(
   parameter int          AW       = 4,
   parameter int          DW       = 8,
   parameter int unsigned RESET_PC = 0
) (
   input  logic          clk,
   input  logic          rst,
`ifdef SINGLE_STEP_EN
   input  logic          step,
`endif
   input  logic [DW-1:0] imem_data,
   input  logic          ovf,
   input  logic          resume,
   output logic [AW-1:0] imem_addr,
   output logic [1:0]    instruct,
   output logic [AW-1:0] operand,
   output logic          inc_en,
   output logic          halted,
   output logic [AW-1:0] pc
);

   localparam logic [AW-1:0] LP_RESET_PC = AW'(RESET_PC);

   localparam logic [1:0] OP_INC  = 2'b00;
   localparam logic [1:0] OP_JNO  = 2'b01;
   localparam logic [1:0] OP_HALT = 2'b10;
   localparam logic [1:0] OP_NOP  = 2'b11;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_WAIT   = 3'd1,
      S_LOAD   = 3'd2,
      S_EXEC   = 3'd3,
      S_HALTED = 3'd4
   } state_t;

   state_t        r_state;
   logic [AW-1:0] r_pc;
   logic [AW-1:0] r_imem_addr;
   logic [1:0]    r_instruct;
   logic [AW-1:0] r_operand;
   logic          r_inc_en;
   logic          r_halted;

   logic [1:0]    w_opcode;
   logic [AW-1:0] w_operand;
   logic          w_advance;

   // Sequential successor of a PC; the AW-bit result wraps modulo 2^AW.
   function automatic logic [AW-1:0] f_pc_next(input logic [AW-1:0] p);
      return p + AW'(1);
   endfunction

   // Next PC for a JNO: the jump is taken only when no overflow is flagged.
   function automatic logic [AW-1:0] f_jno_target(input logic [AW-1:0] p,
                                                   input logic [AW-1:0] tgt,
                                                   input logic          v);
      return v ? f_pc_next(p) : tgt;
   endfunction

   assign w_opcode  = imem_data[DW-1:DW-2];
   assign w_operand = imem_data[AW-1:0];

   // Bits between the opcode and the operand carry no meaning.
   generate
      if (DW > AW + 2) begin : g_pad
         logic w_unused_pad;
         assign w_unused_pad = ^imem_data[DW-3:AW];
      end
   endgenerate

`ifdef SINGLE_STEP_EN
   assign w_advance = step;
`else
   assign w_advance = 1'b1;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_FETCH;
         r_pc        <= LP_RESET_PC;
         r_imem_addr <= LP_RESET_PC;
         r_instruct  <= OP_NOP;
         r_operand   <= '0;
         r_inc_en    <= 1'b0;
         r_halted    <= 1'b0;
      end else begin
         // inc_en is a strobe and is set only on the LOAD->EXEC transition.
         // It therefore can never be high on two consecutive cycles.
         r_inc_en <= 1'b0;
         case (r_state)
            S_FETCH: begin
               if (w_advance) begin
                  r_imem_addr <= r_pc;
                  r_state     <= S_WAIT;
               end
            end
            S_WAIT: begin
               r_state <= S_LOAD;
            end
            // The ROM word is valid here. Latch it and prepare the EXEC strobe
            // so that inc_en and operand line up in the same cycle.
            S_LOAD: begin
               r_instruct <= w_opcode;
               r_operand  <= w_operand;
               r_inc_en   <= (w_opcode == OP_INC);
               r_state    <= S_EXEC;
            end
            S_EXEC: begin
               case (r_instruct)
                  OP_INC: begin
                     r_pc    <= f_pc_next(r_pc);
                     r_state <= S_FETCH;
                  end
                  OP_JNO: begin
                     r_pc    <= f_jno_target(r_pc, r_operand, ovf);
                     r_state <= S_FETCH;
                  end
                  OP_HALT: begin
                     r_halted <= 1'b1;
                     r_state  <= S_HALTED;
                  end
                  OP_NOP: begin
                     r_pc    <= f_pc_next(r_pc);
                     r_state <= S_FETCH;
                  end
                  default: begin
                     r_state <= S_FETCH;
                  end
               endcase
            end
            // instruct still holds HALT from LOAD, which keeps the clock gated.
            // Resuming forces NOP so that the gate opens immediately.
            S_HALTED: begin
               if (resume) begin
                  r_pc       <= f_pc_next(r_pc);
                  r_instruct <= OP_NOP;
                  r_halted   <= 1'b0;
                  r_state    <= S_FETCH;
               end
            end
            default: begin
               r_state <= S_FETCH;
            end
         endcase
      end
   end

   assign imem_addr = r_imem_addr;
   assign instruct  = r_instruct;
   assign operand   = r_operand;
   assign inc_en    = r_inc_en;
   assign halted    = r_halted;
   assign pc        = r_pc;

endmodule
